// File: rtl/bit_position_scanner_if.sv
// bit_position_scanner_if: vector capture and position beat handshakes for bit_position_scanner.
interface bit_position_scanner_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  data;
  logic                 msb_first;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] pos;
  logic                 last;
  logic                 none;
  modport master (
    output in_valid, data, msb_first, out_ready,
    input  in_ready, out_valid, pos, last, none
  );
  modport slave (
    input  in_valid, data, msb_first, out_ready,
    output in_ready, out_valid, pos, last, none
  );
endinterface

// File: rtl/bit_position_scanner.sv
// bit_position_scanner: captures a vector, then emits each set bit index one beat at a time.
module bit_position_scanner #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input logic                  clk,
  input logic                  rst,
  bit_position_scanner_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t               state, state_nxt;
  logic [IN_WIDTH-1:0]  mask;
  logic                 dir;
  logic                 zflag;
  logic [OUT_WIDTH-1:0] hi, lo;
  logic                 single, capture, beat;
  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < IN_WIDTH; i++) if (mask[i]) hi = i[OUT_WIDTH-1:0];
    for (int i = IN_WIDTH - 1; i >= 0; i--) if (mask[i]) lo = i[OUT_WIDTH-1:0];
  end
  assign single = (mask != '0) && ((mask & (mask - IN_WIDTH'(1))) == '0);
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == SCAN;
    bus.pos       = state == SCAN ? (dir ? hi : lo) : '0;
    bus.last      = state == SCAN && (zflag || single);
    bus.none      = state == SCAN && zflag;
    capture       = bus.in_ready && bus.in_valid;
    beat          = bus.out_valid && bus.out_ready;
    state_nxt     = capture ? SCAN : (beat && bus.last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
      dir   <= 1'b1;
      zflag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        mask  <= bus.data;
        dir   <= bus.msb_first;
        zflag <= bus.data == '0;
      end else if (beat) begin
        mask <= bus.last ? '0 : mask & ~(IN_WIDTH'(1) << bus.pos);
      end
    end
  end
endmodule

// File: tb/tb_bit_position_scanner.sv
// tb_bit_position_scanner: randomized checks of both widths against a queue-based position model.
module tb_bit_position_scanner;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];
  always #5 clk = ~clk;
  bit_position_scanner_if #(.IN_WIDTH(8)) b8();
  bit_position_scanner_if #(.IN_WIDTH(5)) b5();
  bit_position_scanner #(.IN_WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  bit_position_scanner #(.IN_WIDTH(5)) u5 (.clk(clk), .rst(rst), .bus(b5.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected beat sequence: set-bit indices in requested order, or a single 0 for an empty vector.
  task automatic build(input logic [255:0] d, input int w, input bit m);
    exp_q.delete();
    for (int k = 0; k < w; k++) begin
      int i = m ? w - 1 - k : k;
      if (((d >> i) & 256'd1) != 0) exp_q.push_back(i);
    end
    if (exp_q.size() == 0) exp_q.push_back(0);
  endtask
  task automatic scan8(input logic [7:0] d, input bit m, input bit bp);
    int idx = 0;
    int cyc = 0;
    bit r;
    build(d, 8, m);
    @(negedge clk);
    check("idle_ready", b8.in_ready, 1);
    b8.in_valid = 1; b8.data = d; b8.msb_first = m; b8.out_ready = 0;
    @(negedge clk);
    b8.in_valid = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      check("valid", b8.out_valid, 1);
      check("busy", b8.in_ready, 0);
      check("pos", b8.pos, exp_q[idx]);
      check("last", b8.last, idx == exp_q.size() - 1);
      check("none", b8.none, d == 0);
      r = bp ? 1'($urandom_range(1)) : 1'b1;
      b8.out_ready = r;
      b8.data = 8'($urandom); b8.msb_first = 1'($urandom); b8.in_valid = 1'($urandom);
      @(negedge clk);
      if (r) idx++;
      cyc++;
    end
    check("scan_beats", idx, exp_q.size());
    b8.in_valid = 0; b8.out_ready = 0;
    check("done_ready", b8.in_ready, 1);
    check("done_valid", b8.out_valid, 0);
  endtask
  task automatic b2b5(input int n);
    logic [4:0] d;
    bit m;
    b5.in_valid = 1; b5.out_ready = 1;
    for (int v = 0; v < n; v++) begin
      d = v == 0 ? 5'b10011 : 5'($urandom);
      m = v == 0 ? 1'b1 : 1'($urandom);
      build(d, 5, m);
      check("b2b_idle_ready", b5.in_ready, 1);
      check("b2b_idle_valid", b5.out_valid, 0);
      b5.data = d; b5.msb_first = m;
      @(negedge clk);
      b5.data = 5'($urandom);
      for (int i = 0; i < exp_q.size(); i++) begin
        check("b2b_valid", b5.out_valid, 1);
        check("b2b_pos", b5.pos, exp_q[i]);
        check("b2b_last", b5.last, i == exp_q.size() - 1);
        check("b2b_none", b5.none, d == 0);
        @(negedge clk);
      end
    end
    b5.in_valid = 0;
    check("b2b_end_ready", b5.in_ready, 1);
  endtask
  initial begin
    rst = 1;
    b8.in_valid = 0; b8.data = '0; b8.msb_first = 0; b8.out_ready = 0;
    b5.in_valid = 0; b5.data = '0; b5.msb_first = 0; b5.out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_ready8", b8.in_ready, 1);
    check("rst_valid8", b8.out_valid, 0);
    check("rst_pos8", b8.pos, 0);
    check("rst_last8", b8.last, 0);
    check("rst_none8", b8.none, 0);
    check("rst_ready5", b5.in_ready, 1);
    check("rst_valid5", b5.out_valid, 0);
    rst = 0;
    scan8(8'b1010_0110, 1, 0);
    scan8(8'b1010_0110, 0, 0);
    scan8(8'h00, 1, 0);
    scan8(8'h80, 0, 0);
    scan8(8'hFF, 1, 1);
    for (int t = 0; t < 20; t++) scan8(8'($urandom), 1'($urandom), 1);
    build(8'hFF, 8, 1);
    @(negedge clk);
    b8.in_valid = 1; b8.data = 8'hFF; b8.msb_first = 1;
    @(negedge clk);
    b8.in_valid = 0; b8.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("pre_rst_pos", b8.pos, exp_q[i]);
      @(negedge clk);
    end
    rst = 1; b8.in_valid = 1;
    @(negedge clk);
    check("mid_rst_ready", b8.in_ready, 1);
    check("mid_rst_valid", b8.out_valid, 0);
    check("mid_rst_pos", b8.pos, 0);
    rst = 0; b8.in_valid = 0;
    @(negedge clk);
    check("post_rst_valid", b8.out_valid, 0);
    check("post_rst_ready", b8.in_ready, 1);
    b8.out_ready = 0;
    b2b5(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
